// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the memory responder: dump FSM state encoding
// and a constant-evaluable ceiling-log2 used to size the array index.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_OUT  = 2'd2,
        ST_DONE = 2'd3
    } dump_state_e;

    // Smallest r with 2**r >= value; used at elaboration time only.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if (value > (1 << i)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Bundle of the controller load/store pins, the preload port, the dump stream
// and the status outputs of the memory responder.
interface mem_responder_if
    import mem_responder_pkg::*;
#(
    parameter int DATA_SIZE    = 32,
    parameter int ADDRESS_SIZE = 32,
    parameter int DEPTH        = 1024
) ();
    localparam int ADDR_BITS = clog2(DEPTH);

    logic                    io_loadEnable;
    logic [ADDRESS_SIZE-1:0] io_loadAddrOut;
    logic [DATA_SIZE-1:0]    io_loadDataIn;
    logic                    io_storeEnable;
    logic [ADDRESS_SIZE-1:0] io_storeAddrOut;
    logic [DATA_SIZE-1:0]    io_storeDataOut;
    logic                    init_valid;
    logic                    init_ready;
    logic [ADDRESS_SIZE-1:0] init_addr;
    logic [DATA_SIZE-1:0]    init_data;
    logic                    dump_start;
    logic                    dump_valid;
    logic                    dump_ready;
    logic [ADDR_BITS-1:0]    dump_addr;
    logic [DATA_SIZE-1:0]    dump_data;
    logic                    dump_busy;
    logic                    dump_done;
    logic                    oob_err;
    logic [31:0]             load_count;
    logic [31:0]             store_count;

    modport slave (
        input  io_loadEnable, io_loadAddrOut, io_storeEnable, io_storeAddrOut,
               io_storeDataOut, init_valid, init_addr, init_data, dump_start, dump_ready,
        output io_loadDataIn, init_ready, dump_valid, dump_addr, dump_data, dump_busy,
               dump_done, oob_err, load_count, store_count
    );

    modport master (
        output io_loadEnable, io_loadAddrOut, io_storeEnable, io_storeAddrOut,
               io_storeDataOut, init_valid, init_addr, init_data, dump_start, dump_ready,
        input  io_loadDataIn, init_ready, dump_valid, dump_addr, dump_data, dump_busy,
               dump_done, oob_err, load_count, store_count
    );
endinterface

// File: rtl/mem_responder_ram.sv
// Word array with one write port and two enabled synchronous read ports.
// Reads are read-first: a read and write to the same word in one cycle return
// the old contents. Only the read registers are reset; the array keeps its data.
module mem_responder_ram #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic                 re0,
    input  logic [ADDR_BITS-1:0] raddr0,
    output logic [DATA_SIZE-1:0] rdata0,
    input  logic                 re1,
    input  logic [ADDR_BITS-1:0] raddr1,
    output logic [DATA_SIZE-1:0] rdata1
);
    localparam int WORDS = 1 << ADDR_BITS;

    logic [DATA_SIZE-1:0] mem_r [WORDS];
    logic [DATA_SIZE-1:0] rdata0_r;
    logic [DATA_SIZE-1:0] rdata1_r;

    // Array write; no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read registers hold their value until the next enabled read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata0_r <= {DATA_SIZE{1'b0}};
            rdata1_r <= {DATA_SIZE{1'b0}};
        end else begin
            if (re0) begin
                rdata0_r <= mem_r[raddr0];
            end
            if (re1) begin
                rdata1_r <= mem_r[raddr1];
            end
        end
    end

    assign rdata0 = rdata0_r;
    assign rdata1 = rdata1_r;
endmodule

// File: rtl/mem_responder.sv
// Memory responder top: arbitrates the single write port (store beats preload),
// serves controller loads with one-cycle latency, streams the whole array out
// through the dump FSM, and tracks out-of-range accesses and traffic counters.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DATA_SIZE    = 32,
    parameter int ADDRESS_SIZE = 32,
    parameter int DEPTH        = 1024
) (
    input logic            clk,
    input logic            rst,
    mem_responder_if.slave bus
);
    localparam int ADDR_BITS = clog2(DEPTH);
    localparam logic [ADDRESS_SIZE-1:0] DEPTH_A  = ADDRESS_SIZE'(DEPTH);
    localparam logic [ADDR_BITS-1:0]    LAST_IDX = ADDR_BITS'(DEPTH - 1);
    localparam logic [ADDR_BITS-1:0]    IDX_ONE  = ADDR_BITS'(1);

    logic                 init_ready_s;
    logic                 init_fire_s;
    logic                 we_s;
    logic [ADDR_BITS-1:0] waddr_s;
    logic [DATA_SIZE-1:0] wdata_s;
    logic                 dump_rd_s;
    logic                 oob_hit_s;
    logic [DATA_SIZE-1:0] load_data_s;
    logic [DATA_SIZE-1:0] dump_data_s;
    dump_state_e          state_r;
    dump_state_e          next_s;
    logic [ADDR_BITS-1:0] idx_r;
    logic                 dump_valid_r;
    logic                 dump_busy_r;
    logic                 dump_done_r;
    logic                 oob_r;
    logic [31:0]          load_count_r;
    logic [31:0]          store_count_r;

    // Write-port arbitration: a controller store always takes the port.
    always_comb begin
        init_ready_s = ~bus.io_storeEnable;
        init_fire_s  = bus.init_valid & init_ready_s;
        we_s         = 1'b0;
        waddr_s      = bus.init_addr[ADDR_BITS-1:0];
        wdata_s      = bus.init_data;
        if (bus.io_storeEnable) begin
            we_s    = 1'b1;
            waddr_s = bus.io_storeAddrOut[ADDR_BITS-1:0];
            wdata_s = bus.io_storeDataOut;
        end else if (init_fire_s) begin
            we_s    = 1'b1;
        end else begin
            we_s    = 1'b0;
        end
    end

    mem_responder_ram #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .we     (we_s),
        .waddr  (waddr_s),
        .wdata  (wdata_s),
        .re0    (bus.io_loadEnable),
        .raddr0 (bus.io_loadAddrOut[ADDR_BITS-1:0]),
        .rdata0 (load_data_s),
        .re1    (dump_rd_s),
        .raddr1 (idx_r),
        .rdata1 (dump_data_s)
    );

    // Dump FSM next-state: one read cycle, then hold the beat until accepted.
    always_comb begin
        next_s    = state_r;
        dump_rd_s = (state_r == ST_RD);
        case (state_r)
            ST_IDLE: begin
                if (bus.dump_start) begin
                    next_s = ST_RD;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_RD: begin
                next_s = ST_OUT;
            end
            ST_OUT: begin
                if (bus.dump_ready && (idx_r == LAST_IDX)) begin
                    next_s = ST_DONE;
                end else if (bus.dump_ready) begin
                    next_s = ST_RD;
                end else begin
                    next_s = ST_OUT;
                end
            end
            ST_DONE: begin
                next_s = ST_IDLE;
            end
            default: begin
                next_s = ST_IDLE;
            end
        endcase
    end

    // Dump FSM state, beat index and registered stream flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            idx_r        <= {ADDR_BITS{1'b0}};
            dump_valid_r <= 1'b0;
            dump_busy_r  <= 1'b0;
            dump_done_r  <= 1'b0;
        end else begin
            state_r      <= next_s;
            dump_valid_r <= (next_s == ST_OUT);
            dump_busy_r  <= (next_s != ST_IDLE);
            dump_done_r  <= (next_s == ST_DONE);
            if ((state_r == ST_IDLE) && bus.dump_start) begin
                idx_r <= {ADDR_BITS{1'b0}};
            end else if ((state_r == ST_OUT) && bus.dump_ready && (idx_r != LAST_IDX)) begin
                idx_r <= idx_r + IDX_ONE;
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    assign oob_hit_s = (bus.io_loadEnable  && (bus.io_loadAddrOut  >= DEPTH_A)) ||
                       (bus.io_storeEnable && (bus.io_storeAddrOut >= DEPTH_A)) ||
                       (init_fire_s        && (bus.init_addr       >= DEPTH_A));

    // Sticky out-of-range flag and saturating traffic counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            oob_r         <= 1'b0;
            load_count_r  <= 32'd0;
            store_count_r <= 32'd0;
        end else begin
            oob_r <= oob_r | oob_hit_s;
            if (bus.io_loadEnable && (load_count_r != 32'hFFFF_FFFF)) begin
                load_count_r <= load_count_r + 32'd1;
            end
            if (bus.io_storeEnable && (store_count_r != 32'hFFFF_FFFF)) begin
                store_count_r <= store_count_r + 32'd1;
            end
        end
    end

    assign bus.io_loadDataIn = load_data_s;
    assign bus.init_ready    = init_ready_s;
    assign bus.dump_valid    = dump_valid_r;
    assign bus.dump_addr     = idx_r;
    assign bus.dump_data     = dump_data_s;
    assign bus.dump_busy     = dump_busy_r;
    assign bus.dump_done     = dump_done_r;
    assign bus.oob_err       = oob_r;
    assign bus.load_count    = load_count_r;
    assign bus.store_count   = store_count_r;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a DEPTH=1024 instance for controller-port,
// preload and out-of-range checks, and a DEPTH=4 instance for the dump stream.
module tb_mem_responder;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_fail;

    mem_responder_if #(.DATA_SIZE(32), .ADDRESS_SIZE(32), .DEPTH(1024)) ifb ();
    mem_responder_if #(.DATA_SIZE(32), .ADDRESS_SIZE(32), .DEPTH(4))    ifs ();

    mem_responder #(.DATA_SIZE(32), .ADDRESS_SIZE(32), .DEPTH(1024)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb.slave));
    mem_responder #(.DATA_SIZE(32), .ADDRESS_SIZE(32), .DEPTH(4)) dut_s (
        .clk (clk), .rst (rst), .bus (ifs.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        ifb.io_loadEnable = 1'b0; ifb.io_loadAddrOut = 32'd0;
        ifb.io_storeEnable = 1'b0; ifb.io_storeAddrOut = 32'd0; ifb.io_storeDataOut = 32'd0;
        ifb.init_valid = 1'b0; ifb.init_addr = 32'd0; ifb.init_data = 32'd0;
        ifb.dump_start = 1'b0; ifb.dump_ready = 1'b0;
        ifs.io_loadEnable = 1'b0; ifs.io_loadAddrOut = 32'd0;
        ifs.io_storeEnable = 1'b0; ifs.io_storeAddrOut = 32'd0; ifs.io_storeDataOut = 32'd0;
        ifs.init_valid = 1'b0; ifs.init_addr = 32'd0; ifs.init_data = 32'd0;
        ifs.dump_start = 1'b0; ifs.dump_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_vec++; if (ifb.io_loadDataIn !== 32'd0) begin n_fail++; $display("FAIL reset_load: got %h want 0", ifb.io_loadDataIn); end
        n_vec++; if ({ifs.dump_valid, ifs.dump_busy, ifs.dump_done} !== 3'b000) begin n_fail++; $display("FAIL reset_dump_flags: got %b want 000", {ifs.dump_valid, ifs.dump_busy, ifs.dump_done}); end
        n_vec++; if (ifs.dump_addr !== 2'd0) begin n_fail++; $display("FAIL reset_dump_addr: got %0d want 0", ifs.dump_addr); end
        n_vec++; if (ifb.oob_err !== 1'b0) begin n_fail++; $display("FAIL reset_oob: got %b want 0", ifb.oob_err); end
        n_vec++; if ({ifb.load_count, ifb.store_count} !== 64'd0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d want 0/0", ifb.load_count, ifb.store_count); end
    endtask

    task automatic test_store_load();
        ifb.io_storeEnable = 1'b1; ifb.io_storeAddrOut = 32'd5; ifb.io_storeDataOut = 32'hDEAD_BEEF;
        @(negedge clk);
        ifb.io_storeEnable = 1'b0;
        ifb.io_loadEnable = 1'b1; ifb.io_loadAddrOut = 32'd5;
        @(negedge clk);
        ifb.io_loadEnable = 1'b0;
        n_vec++; if (ifb.io_loadDataIn !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL store_load: got %h want deadbeef", ifb.io_loadDataIn); end
        @(negedge clk);
        n_vec++; if (ifb.io_loadDataIn !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_hold: got %h want deadbeef", ifb.io_loadDataIn); end
    endtask

    task automatic test_read_first();
        ifb.init_valid = 1'b1; ifb.init_addr = 32'd7; ifb.init_data = 32'h11;
        #1;
        n_vec++; if (ifb.init_ready !== 1'b1) begin n_fail++; $display("FAIL init_ready_free: got %b want 1", ifb.init_ready); end
        @(negedge clk);
        ifb.init_valid = 1'b0;
        ifb.io_loadEnable = 1'b1; ifb.io_loadAddrOut = 32'd7;
        ifb.io_storeEnable = 1'b1; ifb.io_storeAddrOut = 32'd7; ifb.io_storeDataOut = 32'h22;
        @(negedge clk);
        ifb.io_storeEnable = 1'b0;
        n_vec++; if (ifb.io_loadDataIn !== 32'h11) begin n_fail++; $display("FAIL read_first_old: got %h want 11", ifb.io_loadDataIn); end
        @(negedge clk);
        ifb.io_loadEnable = 1'b0;
        n_vec++; if (ifb.io_loadDataIn !== 32'h22) begin n_fail++; $display("FAIL read_first_new: got %h want 22", ifb.io_loadDataIn); end
    endtask

    task automatic test_init_collision();
        ifb.io_storeEnable = 1'b1; ifb.io_storeAddrOut = 32'd9; ifb.io_storeDataOut = 32'hAAAA;
        ifb.init_valid = 1'b1; ifb.init_addr = 32'd10; ifb.init_data = 32'hBBBB;
        #1;
        n_vec++; if (ifb.init_ready !== 1'b0) begin n_fail++; $display("FAIL init_blocked: got %b want 0", ifb.init_ready); end
        @(negedge clk);
        ifb.io_storeEnable = 1'b0;
        #1;
        n_vec++; if (ifb.init_ready !== 1'b1) begin n_fail++; $display("FAIL init_retry: got %b want 1", ifb.init_ready); end
        @(negedge clk);
        ifb.init_valid = 1'b0;
        ifb.io_loadEnable = 1'b1; ifb.io_loadAddrOut = 32'd9;
        @(negedge clk);
        n_vec++; if (ifb.io_loadDataIn !== 32'hAAAA) begin n_fail++; $display("FAIL collide_store_word: got %h want aaaa", ifb.io_loadDataIn); end
        ifb.io_loadAddrOut = 32'd10;
        @(negedge clk);
        ifb.io_loadEnable = 1'b0;
        n_vec++; if (ifb.io_loadDataIn !== 32'hBBBB) begin n_fail++; $display("FAIL collide_init_word: got %h want bbbb", ifb.io_loadDataIn); end
        n_vec++; if (ifb.load_count !== 32'd5) begin n_fail++; $display("FAIL load_count: got %0d want 5", ifb.load_count); end
        n_vec++; if (ifb.store_count !== 32'd3) begin n_fail++; $display("FAIL store_count: got %0d want 3", ifb.store_count); end
    endtask

    task automatic test_oob();
        ifb.init_valid = 1'b1; ifb.init_addr = 32'd3; ifb.init_data = 32'h33;
        @(negedge clk);
        ifb.init_valid = 1'b0;
        n_vec++; if (ifb.oob_err !== 1'b0) begin n_fail++; $display("FAIL oob_clear: got %b want 0", ifb.oob_err); end
        ifb.io_loadEnable = 1'b1; ifb.io_loadAddrOut = 32'd1027;
        @(negedge clk);
        ifb.io_loadEnable = 1'b0;
        n_vec++; if (ifb.io_loadDataIn !== 32'h33) begin n_fail++; $display("FAIL oob_wrap: got %h want 33", ifb.io_loadDataIn); end
        n_vec++; if (ifb.oob_err !== 1'b1) begin n_fail++; $display("FAIL oob_set: got %b want 1", ifb.oob_err); end
        repeat (3) @(negedge clk);
        n_vec++; if (ifb.oob_err !== 1'b1) begin n_fail++; $display("FAIL oob_sticky: got %b want 1", ifb.oob_err); end
    endtask

    task automatic test_dump();
        int  beat;
        int  dones;
        bit  stalled;
        bit  finished;
        logic [31:0] held;
        for (int i = 0; i < 4; i++) begin
            ifs.init_valid = 1'b1; ifs.init_addr = 32'(i); ifs.init_data = 32'(i + 1);
            @(negedge clk);
        end
        ifs.init_valid = 1'b0;
        ifs.dump_start = 1'b1;
        @(negedge clk);
        ifs.dump_start = 1'b0;
        beat = 0; dones = 0; stalled = 1'b0; finished = 1'b0; held = 32'd0;
        for (int c = 0; c < 40 && !finished; c++) begin
            if (ifs.dump_done === 1'b1) begin
                dones++;
                finished = (beat == 4);
            end
            if (ifs.dump_valid === 1'b1) begin
                n_vec++; if (ifs.dump_addr !== 2'(beat)) begin n_fail++; $display("FAIL dump_addr: got %0d want %0d", ifs.dump_addr, beat); end
                n_vec++; if (ifs.dump_data !== 32'(beat + 1)) begin n_fail++; $display("FAIL dump_data: got %h want %h", ifs.dump_data, beat + 1); end
                if (!stalled) begin
                    held = ifs.dump_data;
                    stalled = 1'b1;
                    ifs.dump_ready = 1'b0;
                end else begin
                    n_vec++; if (ifs.dump_data !== held) begin n_fail++; $display("FAIL dump_stable: got %h want %h", ifs.dump_data, held); end
                    stalled = 1'b0;
                    ifs.dump_ready = 1'b1;
                    beat++;
                end
            end else begin
                ifs.dump_ready = 1'b1;
            end
            @(negedge clk);
        end
        ifs.dump_ready = 1'b0;
        n_vec++; if (beat !== 4) begin n_fail++; $display("FAIL dump_beats: got %0d want 4", beat); end
        n_vec++; if (dones !== 1) begin n_fail++; $display("FAIL dump_done_pulses: got %0d want 1", dones); end
        n_vec++; if ({ifs.dump_busy, ifs.dump_done} !== 2'b00) begin n_fail++; $display("FAIL dump_idle_after: got %b want 00", {ifs.dump_busy, ifs.dump_done}); end
    endtask

    task automatic test_reset_mid_dump();
        bit hit;
        int dones;
        hit = 1'b0;
        dones = 0;
        ifs.dump_start = 1'b1;
        @(negedge clk);
        ifs.dump_start = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            if (ifs.dump_valid === 1'b1 && ifs.dump_addr === 2'd2) begin
                rst = 1'b1;
                ifs.dump_ready = 1'b0;
                hit = 1'b1;
            end else begin
                ifs.dump_ready = 1'b1;
            end
            @(negedge clk);
        end
        rst = 1'b0;
        n_vec++; if (hit !== 1'b1) begin n_fail++; $display("FAIL rst_reach_beat2: got %b want 1", hit); end
        n_vec++; if ({ifs.dump_valid, ifs.dump_busy, ifs.dump_done} !== 3'b000) begin n_fail++; $display("FAIL rst_abort: got %b want 000", {ifs.dump_valid, ifs.dump_busy, ifs.dump_done}); end
        ifs.dump_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (ifs.dump_done === 1'b1) dones++;
            @(negedge clk);
        end
        n_vec++; if (dones !== 0) begin n_fail++; $display("FAIL rst_no_done: got %0d want 0", dones); end
        ifs.io_loadEnable = 1'b1; ifs.io_loadAddrOut = 32'd2;
        ifb.io_loadEnable = 1'b1; ifb.io_loadAddrOut = 32'd5;
        @(negedge clk);
        ifs.io_loadEnable = 1'b0;
        ifb.io_loadEnable = 1'b0;
        n_vec++; if (ifs.io_loadDataIn !== 32'd3) begin n_fail++; $display("FAIL rst_retain_small: got %h want 3", ifs.io_loadDataIn); end
        n_vec++; if (ifb.io_loadDataIn !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rst_retain_big: got %h want deadbeef", ifb.io_loadDataIn); end
        n_vec++; if (ifb.oob_err !== 1'b0) begin n_fail++; $display("FAIL rst_oob_cleared: got %b want 0", ifb.oob_err); end
    endtask

    initial begin
        n_vec = 0;
        n_fail = 0;
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_store_load();
        test_read_first();
        test_init_collision();
        test_oob();
        test_dump();
        test_reset_mid_dump();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
